// File: rtl/hub75_scan_engine.sv
// HUB75 scan engine: shifts one bit-plane per row, latches it, then displays it for a BCM on-time.
// Optional macro HUB75_ROW_BLANK_EN adds 4 blank cycles after each row-address change.
module hub75_scan_engine #(
    parameter int unsigned PANEL_WIDTH = 64,
    parameter int unsigned SCAN_ROWS   = 32,
    parameter int unsigned COLOR_DEPTH = 8,
    localparam int unsigned COL_W      = $clog2(PANEL_WIDTH),
    localparam int unsigned ROW_W      = $clog2(SCAN_ROWS),
    localparam int unsigned PLANE_W    = (COLOR_DEPTH > 1) ? $clog2(COLOR_DEPTH) : 1,
    localparam int unsigned TIMER_W    = 8 + COLOR_DEPTH
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic                     enable,
    input  logic [7:0]               brightness,
    output logic                     rd_en,
    output logic [ROW_W+COL_W-1:0]   rd_addr,
    input  logic [6*COLOR_DEPTH-1:0] rd_data,
    output logic                     hub_r0,
    output logic                     hub_g0,
    output logic                     hub_b0,
    output logic                     hub_r1,
    output logic                     hub_g1,
    output logic                     hub_b1,
    output logic [ROW_W-1:0]         hub_addr,
    output logic                     hub_clk,
    output logic                     hub_lat,
    output logic                     hub_oe_n,
    output logic                     frame_done,
    output logic                     busy
);

    typedef enum logic [2:0] {StIdle, StPrefetch, StShift, StWait, StLatch} state_e;

    state_e               state_q, state_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [PLANE_W-1:0]   plane_q, plane_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic                 phase_q, phase_d;
    logic [TIMER_W-1:0]   timer_q;
    logic [TIMER_W-1:0]   on_time;
    logic [ROW_W-1:0]     addr_q;
    logic [5:0]           colour_q;
    logic [5:0]           colour;
    logic [5:0]           rd_bits;
    logic [COL_W-1:0]     rd_col;
    logic                 show;
    logic                 load_timer;
    logic                 blanking;
    logic                 timer_done;
    logic                 last_col;
    logic                 last_plane;
    logic                 last_row;

    assign last_col   = (col_q == COL_W'(PANEL_WIDTH - 1));
    assign last_plane = (plane_q == PLANE_W'(COLOR_DEPTH - 1));
    assign last_row   = (row_q == ROW_W'(SCAN_ROWS - 1));
    assign on_time    = (TIMER_W'(brightness) + TIMER_W'(1)) << plane_q;

    // A timer expiring this cycle already counts as expired, so the next LATCH is not delayed.
    assign timer_done = !blanking && (timer_q <= TIMER_W'(1));

    // Channel order in rd_data from MSB: R0 G0 B0 R1 G1 B1; rd_bits keeps the same order.
    always_comb begin
        logic [COLOR_DEPTH-1:0] chan;
        rd_bits = '0;
        chan    = '0;
        for (int i = 0; i < 6; i++) begin
            chan       = rd_data[i*COLOR_DEPTH +: COLOR_DEPTH];
            rd_bits[i] = chan[plane_q];
        end
    end

    // Column data is live from the buffer in cycle A and held from the register afterwards.
    assign show   = (state_q == StShift) && !phase_q;
    assign colour = show ? rd_bits : colour_q;
    assign hub_r0 = colour[5];
    assign hub_g0 = colour[4];
    assign hub_b0 = colour[3];
    assign hub_r1 = colour[2];
    assign hub_g1 = colour[1];
    assign hub_b1 = colour[0];

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        plane_d    = plane_q;
        col_d      = col_q;
        phase_d    = phase_q;
        rd_en      = 1'b0;
        rd_col     = '0;
        hub_clk    = 1'b0;
        hub_lat    = 1'b0;
        frame_done = 1'b0;
        load_timer = 1'b0;
        unique case (state_q)
            StIdle: begin
                row_d   = '0;
                plane_d = '0;
                if (enable) state_d = StPrefetch;
            end
            StPrefetch: begin
                rd_en   = 1'b1;
                col_d   = '0;
                phase_d = 1'b0;
                state_d = StShift;
            end
            StShift: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    hub_clk = 1'b1;
                    phase_d = 1'b0;
                    if (!last_col) begin
                        rd_en  = 1'b1;
                        rd_col = col_q + 1'b1;
                        col_d  = col_q + 1'b1;
                    end else begin
                        state_d = timer_done ? StLatch : StWait;
                    end
                end
            end
            StWait: begin
                if (timer_done) state_d = StLatch;
            end
            StLatch: begin
                hub_lat    = 1'b1;
                load_timer = 1'b1;
                if (last_plane) begin
                    plane_d = '0;
                    if (last_row) begin
                        row_d      = '0;
                        frame_done = 1'b1;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    plane_d = plane_q + 1'b1;
                end
                state_d = (frame_done && !enable) ? StIdle : StPrefetch;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_addr = '0;
        if (rd_en) rd_addr = {row_q, rd_col};
    end

    assign hub_addr = (state_q == StLatch) ? row_q : addr_q;
    assign busy     = (state_q != StIdle) || (timer_q != '0);

    always_comb begin
        hub_oe_n = 1'b1;
        if (state_q != StIdle && state_q != StLatch && !blanking && timer_q != '0) begin
            hub_oe_n = 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q  <= StIdle;
            row_q    <= '0;
            plane_q  <= '0;
            col_q    <= '0;
            phase_q  <= 1'b0;
            colour_q <= '0;
            addr_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            plane_q <= plane_d;
            col_q   <= col_d;
            phase_q <= phase_d;
            if (show) colour_q <= rd_bits;
            if (hub_lat) addr_q <= row_q;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            timer_q <= '0;
        end else if (load_timer) begin
            timer_q <= on_time;
        end else if (!blanking && timer_q != '0) begin
            timer_q <= timer_q - 1'b1;
        end
    end

`ifdef HUB75_ROW_BLANK_EN
    logic [2:0] blank_q;

    // Plane 0 is the latch that moves hub_addr; give the row drivers time to settle.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            blank_q <= '0;
        end else if (load_timer && plane_q == '0) begin
            blank_q <= 3'd4;
        end else if (blank_q != '0) begin
            blank_q <= blank_q - 1'b1;
        end
    end

    assign blanking = (blank_q != '0);
`else
    assign blanking = 1'b0;
`endif

endmodule

// File: tb/tb_hub75_scan_engine.sv
// Directed bench for hub75_scan_engine on a 4x2 panel with 2 bit-planes; expectations are
// queued from a frame-buffer model and popped as the engine reads, clocks, latches and displays.
module tb_hub75_scan_engine;

    localparam int unsigned W  = 4;
    localparam int unsigned SR = 2;
    localparam int unsigned CD = 2;

    logic        clk;
    logic        ARESET;
    logic        enable;
    logic [7:0]  brightness;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic [11:0] rd_data;
    logic        hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1;
    logic [0:0]  hub_addr;
    logic        hub_clk, hub_lat, hub_oe_n, frame_done, busy;

    hub75_scan_engine #(
        .PANEL_WIDTH (W),
        .SCAN_ROWS   (SR),
        .COLOR_DEPTH (CD)
    ) dut (
        .ACLK       (clk),
        .ARESET     (ARESET),
        .enable     (enable),
        .brightness (brightness),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .hub_r0     (hub_r0),
        .hub_g0     (hub_g0),
        .hub_b0     (hub_b0),
        .hub_r1     (hub_r1),
        .hub_g1     (hub_g1),
        .hub_b1     (hub_b1),
        .hub_addr   (hub_addr),
        .hub_clk    (hub_clk),
        .hub_lat    (hub_lat),
        .hub_oe_n   (hub_oe_n),
        .frame_done (frame_done),
        .busy       (busy)
    );

    logic [11:0] mem [8];
    logic [2:0]  addr_q [$];
    logic [5:0]  col_q [$];
    logic [1:0]  lat_q [$];
    int          oe_q [$];

    int total = 0;
    int bad   = 0;
    int cyc = 0, lat_cnt = 0, last_lat = 0, clk_cnt = 0, oe_cnt = 0, extra = 0, guard = 0;
    bit mon = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous frame buffer: data valid the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] colour_of(input logic [11:0] w, input int p);
        logic [5:0] v;
        for (int ch = 0; ch < 6; ch++) v[ch] = w[ch*CD + p];
        return v;
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
        if (mon) begin
            if (rd_en) begin
                if (addr_q.size() > 0) check("rd_addr", 32'(rd_addr), 32'(addr_q.pop_front()));
                else extra++;
            end
            if (hub_clk) begin
                clk_cnt++;
                if (col_q.size() > 0) begin
                    check("colour", 32'({hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1}),
                          32'(col_q.pop_front()));
                end else extra++;
            end
            if (hub_lat) begin
                if (lat_q.size() > 0) begin
                    logic [1:0] e;
                    e = lat_q.pop_front();
                    check("hub_addr", 32'(hub_addr), 32'(e[1]));
                    check("frame_done", 32'(frame_done), 32'(e[0]));
                end else extra++;
                check("lat_oe_n", 32'(hub_oe_n), 1);
                check("clk_edges", clk_cnt, W);
                clk_cnt  = 0;
                last_lat = cyc;
                lat_cnt++;
            end
            if (!hub_oe_n) begin
                if (oe_cnt == 0) check("oe_start", cyc - last_lat, 1);
                oe_cnt++;
            end else if (oe_cnt != 0) begin
                if (oe_q.size() > 0) check("oe_len", oe_cnt, oe_q.pop_front());
                else extra++;
                oe_cnt = 0;
            end
            if (frame_done) check("fd_with_lat", 32'(hub_lat), 1);
        end
    endtask

    initial begin
        logic [3:0] pat;
        ARESET     = 1'b1;
        enable     = 1'b0;
        brightness = 8'd0;
        rd_data    = '0;
        pat        = 4'b1101;  // row 0 R0 plane-0 bits for cols 0..3 = 1,0,1,1
        for (int i = 0; i < 8; i++) mem[i] = 12'($urandom);
        for (int c = 0; c < 4; c++) mem[c][10] = pat[c];

        // Two frames: brightness 0 then 3; the last plane of frame 2 is blanked by IDLE.
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < 2; r++) begin
                for (int p = 0; p < 2; p++) begin
                    for (int c = 0; c < 4; c++) begin
                        addr_q.push_back(3'(r*4 + c));
                        col_q.push_back(colour_of(mem[r*4 + c], p));
                    end
                    lat_q.push_back({1'(r), 1'(r == 1 && p == 1)});
                    if (!(f == 1 && r == 1 && p == 1)) oe_q.push_back(((f == 0 ? 0 : 3) + 1) << p);
                end
            end
        end

        // Reset state and idle hold.
        repeat (3) step();
        check("rst_oe_n", 32'(hub_oe_n), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_rd_en", 32'(rd_en), 0);
        check("rst_outs", 32'({rd_addr, hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1,
                               hub_addr, hub_clk, hub_lat, frame_done}), 0);
        ARESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("idle_oe_n", 32'(hub_oe_n), 1);
            check("idle_busy", 32'(busy), 0);
            check("idle_rd_en", 32'(rd_en), 0);
        end

        // Frame 1 at brightness 0.
        mon    = 1'b1;
        enable = 1'b1;
        guard  = 0;
        while (lat_cnt < 4 && guard < 500) begin
            step();
            guard++;
        end
        check("f1_latches", lat_cnt, 4);
        step();
        check("f2_prefetch_en", 32'(rd_en), 1);
        check("f2_prefetch_addr", 32'(rd_addr), 0);
        brightness = 8'd3;

        // Frame 2, enable dropped after its second latch.
        guard = 0;
        while (lat_cnt < 6 && guard < 500) begin
            step();
            guard++;
        end
        enable = 1'b0;
        while (lat_cnt < 8 && guard < 500) begin
            step();
            guard++;
        end
        check("f2_latches", lat_cnt, 8);
        guard = 0;
        while (busy && guard < 100) begin
            step();
            guard++;
        end
        check("busy_fall", cyc - last_lat, 9);
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_oe_n", 32'(hub_oe_n), 1);
            check("post_busy", 32'(busy), 0);
            check("post_rd_en", 32'(rd_en), 0);
        end
        check("addr_left", addr_q.size(), 0);
        check("colour_left", col_q.size(), 0);
        check("lat_left", lat_q.size(), 0);
        check("oe_left", oe_q.size(), 0);
        check("extra_events", extra, 0);

        // Reset in the middle of a display window, then restart.
        mon    = 1'b0;
        enable = 1'b1;
        guard  = 0;
        while (hub_oe_n && guard < 100) begin
            step();
            guard++;
        end
        check("t6_oe_low", 32'(hub_oe_n), 0);
        ARESET = 1'b1;
        step();
        check("t6_oe_n", 32'(hub_oe_n), 1);
        check("t6_lat", 32'(hub_lat), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_rd_en", 32'(rd_en), 0);
        ARESET = 1'b0;
        step();
        check("t6_restart_en", 32'(rd_en), 1);
        check("t6_restart_addr", 32'(rd_addr), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
